// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: reset/NOP constants, opcode values and field slices.
package mips_pkg;

   localparam int unsigned XLEN      = 32;
   localparam logic [31:0] PC_RESET  = 32'h0000_0000;
   localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
   localparam logic [31:0] PC_STEP   = 32'd4;

   localparam logic [5:0]  OPC_LW    = 6'b100011;
   localparam logic [5:0]  OPC_RTYPE = 6'b000000;

   localparam int unsigned OPC_HI = 31;
   localparam int unsigned OPC_LO = 26;
   localparam int unsigned RS_HI  = 25;
   localparam int unsigned RS_LO  = 21;
   localparam int unsigned RT_HI  = 20;
   localparam int unsigned RT_LO  = 16;

   // Fetch addresses are word aligned; low two bits of a redirect are dropped.
   function automatic logic [31:0] pc_align(input logic [31:0] addr);
      return addr & ~32'd3;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that saturates at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (inc && (r_count != '1)) begin
         r_count <= r_count + W'(1);
      end
   end

   assign count = r_count;

endmodule

// File: rtl/fetch_pipe_ctrl.sv
// IF stage control: PC register, IF/ID register, ID/EX bubble select, perf counters, stall watchdog.
module fetch_pipe_ctrl
   import mips_pkg::*;
#(
   parameter logic [31:0] PC_RESET  = mips_pkg::PC_RESET,
   parameter logic [31:0] NOP_WORD  = mips_pkg::NOP_WORD,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned MAX_STALL = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             flush,
   input  logic [31:0]      branch_target,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_rdata,
   input  logic             imem_ready,
   output logic [31:0]      if_id_ins,
   output logic [31:0]      if_id_pc4,
   output logic             if_id_valid,
   output logic             id_ex_bubble,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] bubble_count,
   output logic             stall_err
);

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_ins;
   logic [XLEN-1:0] r_pc4;
   logic            r_valid;
   logic [3:0]      r_stall_run;
   logic            r_stall_err;

   logic            w_stall_hon;
   logic            w_imem_wait;
   logic [XLEN-1:0] w_pc_next;
   logic [4:0]      w_run_inc;

   // Flush wins over stall; a stall only takes effect when no redirect is pending.
   assign w_stall_hon = stall & ~flush;
   assign w_imem_wait = ~flush & ~stall & ~imem_ready;
   assign w_pc_next   = r_pc + PC_STEP;
   assign w_run_inc   = 5'(r_stall_run) + 5'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc    <= PC_RESET;
         r_ins   <= NOP_WORD;
         r_pc4   <= '0;
         r_valid <= 1'b0;
      end else if (flush) begin
         r_pc    <= pc_align(branch_target);
         r_ins   <= NOP_WORD;
         r_pc4   <= '0;
         r_valid <= 1'b0;
      end else if (stall) begin
         r_pc    <= r_pc;
      end else if (!imem_ready) begin
         r_ins   <= NOP_WORD;
         r_valid <= 1'b0;
      end else begin
         r_ins   <= imem_rdata;
         r_pc4   <= w_pc_next;
         r_valid <= 1'b1;
         r_pc    <= w_pc_next;
      end
   end

   // Consecutive-stall run length; held at 15 so it never wraps back under the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_run <= '0;
         r_stall_err <= 1'b0;
      end else if (w_stall_hon) begin
         if (r_stall_run != 4'hF) begin
            r_stall_run <= r_stall_run + 4'd1;
         end
         if (w_run_inc > 5'(MAX_STALL)) begin
            r_stall_err <= 1'b1;
         end
      end else begin
         r_stall_run <= '0;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_stall_hon),
      .count (stall_count)
   );

   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_imem_wait),
      .count (bubble_count)
   );

   assign imem_addr    = r_pc;
   assign if_id_ins    = r_ins;
   assign if_id_pc4    = r_pc4;
   assign if_id_valid  = r_valid;
   assign id_ex_bubble = w_stall_hon;
   assign stall_err    = r_stall_err;

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Scoreboard bench for fetch_pipe_ctrl: directed plan, random traffic, counter saturation.
module tb_fetch_pipe_ctrl;
   import mips_pkg::*;

   localparam int unsigned CNT_W     = 16;
   localparam int unsigned MAX_STALL = 2;
   localparam int          CNT_MAX   = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst_n;
   logic             stall;
   logic             flush;
   logic [31:0]      branch_target;
   logic [31:0]      imem_addr;
   logic [31:0]      imem_rdata;
   logic             imem_ready;
   logic [31:0]      if_id_ins;
   logic [31:0]      if_id_pc4;
   logic             if_id_valid;
   logic             id_ex_bubble;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] bubble_count;
   logic             stall_err;

   fetch_pipe_ctrl #(
      .PC_RESET  (32'h0000_0000),
      .NOP_WORD  (32'h0000_0000),
      .CNT_W     (CNT_W),
      .MAX_STALL (MAX_STALL)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .flush         (flush),
      .branch_target (branch_target),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .imem_ready    (imem_ready),
      .if_id_ins     (if_id_ins),
      .if_id_pc4     (if_id_pc4),
      .if_id_valid   (if_id_valid),
      .id_ex_bubble  (id_ex_bubble),
      .stall_count   (stall_count),
      .bubble_count  (bubble_count),
      .stall_err     (stall_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
      logic [31:0] pc4;
      logic        valid;
      logic [15:0] sc;
      logic [15:0] bc;
      logic        err;
      logic        bub;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   // Architectural reference state.
   longint m_pc;
   logic [31:0] m_ins, m_pc4;
   logic m_valid, m_err;
   int   m_sc, m_bc, m_run;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %08h want %08h (t=%0t)", nm, act, want, $time);
      end
   endfunction

   task automatic model_reset();
      m_pc = 0; m_ins = NOP_WORD; m_pc4 = 0; m_valid = 1'b0;
      m_sc = 0; m_bc = 0; m_run = 0; m_err = 1'b0;
   endtask

   // One clock edge described by the priority rules, with plain integer arithmetic.
   task automatic model_step(input logic s, input logic f, input logic [31:0] bt,
                             input logic rdy, input logic [31:0] rd);
      if (f) begin
         m_pc = (bt / 4) * 4;
         m_ins = NOP_WORD; m_pc4 = 0; m_valid = 1'b0;
         m_run = 0;
      end else if (s) begin
         if (m_sc < CNT_MAX) m_sc++;
         m_run++;
         if (m_run > MAX_STALL) m_err = 1'b1;
      end else begin
         m_run = 0;
         if (!rdy) begin
            m_ins = NOP_WORD; m_valid = 1'b0;
            if (m_bc < CNT_MAX) m_bc++;
         end else begin
            m_pc  = (m_pc + 4) % 64'h1_0000_0000;
            m_ins = rd; m_pc4 = 32'(m_pc); m_valid = 1'b1;
         end
      end
   endtask

   // Drive one cycle at the falling edge; optionally pulse rst_n inside the low phase.
   task automatic cyc(input logic s, input logic f, input logic [31:0] bt,
                      input logic rdy, input logic [31:0] rd, input logic do_rst);
      exp_t e;
      stall = s; flush = f; branch_target = bt; imem_ready = rdy; imem_rdata = rd;
      if (do_rst) begin
         rst_n = 1'b0;
         model_reset();
      end
      e.pc = 32'(m_pc); e.ins = m_ins; e.pc4 = m_pc4; e.valid = m_valid;
      e.sc = 16'(m_sc); e.bc = 16'(m_bc); e.err = m_err; e.bub = s & ~f;
      exp_q.push_back(e);
      model_step(s, f, bt, rdy, rd);
      if (do_rst) begin
         #3;
         rst_n = 1'b1;
      end
      @(negedge clk);
   endtask

   // Monitor: compares the DUT against the oldest expectation, 2 ns after each falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("imem_addr",    imem_addr,             e.pc);
            chk("if_id_ins",    if_id_ins,             e.ins);
            chk("if_id_pc4",    if_id_pc4,             e.pc4);
            chk("if_id_valid",  32'(if_id_valid),      32'(e.valid));
            chk("stall_count",  32'(stall_count),      32'(e.sc));
            chk("bubble_count", 32'(bubble_count),     32'(e.bc));
            chk("stall_err",    32'(stall_err),        32'(e.err));
            chk("id_ex_bubble", 32'(id_ex_bubble),     32'(e.bub));
         end
      end
   end

   initial begin
      logic [31:0] lw_word;
      lw_word = {OPC_LW, 5'd1, 5'd2, 16'h0004};
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0; branch_target = '0;
      imem_ready = 1'b0; imem_rdata = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Straight-line fetch; third word is a load so the next stall is a load-use hazard.
      cyc(0, 0, 0, 1, 32'hAAAA_0001, 0);
      cyc(0, 0, 0, 1, 32'hBBBB_0002, 0);
      cyc(0, 0, 0, 1, lw_word,       0);
      cyc(1, 0, 0, 1, 32'hDEAD_BEEF, 0);
      cyc(0, 0, 0, 1, 32'hDDDD_0004, 0);
      // Flush and stall together: redirect wins, low address bits dropped.
      cyc(1, 1, 32'h0000_0103, 1, 32'h1234_5678, 0);
      cyc(0, 0, 0, 1, 32'h0000_0111, 0);
      // Three imem wait cycles, then resume.
      cyc(0, 0, 0, 0, 32'hBAD0_0001, 0);
      cyc(0, 0, 0, 0, 32'hBAD0_0002, 0);
      cyc(0, 0, 0, 0, 32'hBAD0_0003, 0);
      cyc(0, 0, 0, 1, 32'h0000_0222, 0);
      // Three consecutive stalls trip the watchdog; it stays set after stall drops.
      cyc(1, 0, 0, 1, 32'h0, 0);
      cyc(1, 0, 0, 1, 32'h0, 0);
      cyc(1, 0, 0, 1, 32'h0, 0);
      cyc(0, 0, 0, 0, 32'h0, 0);
      cyc(0, 0, 0, 1, 32'h0000_0333, 0);
      // Async reset pulse within the low phase of the clock.
      cyc(0, 0, 0, 1, 32'h0000_0444, 1);
      cyc(0, 0, 0, 1, 32'h0000_0555, 0);
      // PC wrap at the top of the address space.
      cyc(0, 1, 32'hFFFF_FFFE, 1, 32'h0, 0);
      cyc(0, 0, 0, 1, 32'h0000_0666, 0);
      cyc(0, 0, 0, 1, 32'h0000_0777, 0);

      for (int i = 0; i < 3000; i++) begin
         logic s, f, rdy, rr;
         s   = ($urandom_range(0, 99) < 30);
         f   = ($urandom_range(0, 9) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         rr  = ($urandom_range(0, 199) == 0);
         cyc(s, f, $urandom, rdy, $urandom, rr);
      end

      // Drive the stall counter well past its ceiling.
      cyc(0, 0, 0, 1, 32'h0, 1);
      for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
         cyc(1, 0, 0, 1, $urandom, 0);
      end
      cyc(0, 0, 0, 1, 32'h0000_0888, 0);
      cyc(0, 0, 0, 1, 32'h0000_0999, 0);

      @(negedge clk);
      #5;
      if (exp_q.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_pipe_ctrl.md
Name: fetch_pipe_ctrl

Overview:
Front end of the 5-stage MIPS pipeline. It consumes the stall request from the load-use hazard detector and the flush request from branch resolution. It owns the PC register, the imem fetch address and the IF/ID pipeline register, and drives the bubble-select into the ID/EX control mux. It also keeps saturating performance counters and a sticky stall watchdog flag for debug.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset
NOP_WORD, 32'h0000_0000, instruction word injected on flush/fetch bubble (sll $0,$0,0)
CNT_W, 16, width of performance counters
MAX_STALL, 2, max consecutive stall cycles before stall_err sets (1..15)

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  load-use stall request from hazard unit (combinational, same cycle)
flush  in  1  branch/jump taken; redirect fetch
branch_target  in  32  redirect address, valid when flush=1
imem_addr  out  32  fetch address (= pc)
imem_rdata  in  32  fetched instruction, valid when imem_ready=1
imem_ready  in  1  imem returns data this cycle
if_id_ins  out  32  IF/ID instruction register
if_id_pc4  out  32  IF/ID PC+4 register
if_id_valid  out  1  IF/ID holds a real instruction
id_ex_bubble  out  1  select NOP controls into ID/EX this cycle
stall_count  out  CNT_W  cycles in which a stall was honoured
bubble_count  out  CNT_W  cycles in which an imem-wait bubble was inserted
stall_err  out  1  sticky: stall held longer than MAX_STALL cycles

Behaviour:
- Reset (async, rst_n=0): pc=PC_RESET, if_id_ins=NOP_WORD, if_id_pc4=0, if_id_valid=0, counters=0, stall_err=0, internal consecutive-stall count=0. Assertion mid-operation clears all state immediately; the first fetch after deassertion is from PC_RESET.
- imem_addr = pc (combinational from register). id_ex_bubble = stall & ~flush (combinational, zero latency).
- Per rising edge, priority flush > stall > imem wait > advance:
  - flush: pc <= {branch_target[31:2],2'b00}; if_id_ins <= NOP_WORD; if_id_pc4 <= 0; if_id_valid <= 0. A stall in the same cycle is ignored and not counted.
  - stall (no flush): pc, if_id_ins, if_id_pc4, if_id_valid hold; stall_count += 1.
  - ~imem_ready (no flush/stall): pc holds; if_id_ins <= NOP_WORD; if_id_valid <= 0; if_id_pc4 holds; bubble_count += 1.
  - advance: if_id_ins <= imem_rdata; if_id_pc4 <= pc+4; if_id_valid <= 1; pc <= pc+4.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000. Bits [1:0] of pc are always 0.
- Counters saturate at all-ones and never wrap.
- Watchdog: a 4-bit consecutive-stall count increments on each honoured stall and clears on any non-stall cycle, including flush. When it would exceed MAX_STALL, stall_err sets on that edge. Only reset clears stall_err.
- A held IF/ID during stall means imem_rdata is discarded. The same pc is re-fetched next cycle, so no skid buffer is needed.

Decomposition:
- Shared package mips_pkg: NOP_WORD, OPC_LW=6'b100011, OPC_RTYPE=6'b000000, instruction field slices (OPC 31:26, RS 25:21, RT 20:16), PC_RESET.
- Sub-module sat_counter (parameter W; inputs clk, rst_n, inc; output count), instantiated twice.

Test Plan:
- Reset then 4 cycles imem_ready=1, rdata=A,B,C,D: imem_addr 0,4,8,C; if_id_ins A..D one cycle late; if_id_pc4 4,8,C,10; valid=1 from cycle 1.
- Single-cycle stall with if_id_ins=lw at pc 8: pc holds at 0xC for one cycle; if_id_ins holds; id_ex_bubble=1 that cycle only; stall_count=1; stall_err=0.
- flush=1 and stall=1 together, branch_target=0x103: pc=0x100; if_id_ins=NOP_WORD, valid=0; id_ex_bubble=0; stall_count unchanged.
- imem_ready=0 for 3 cycles: pc held; if_id_ins=NOP_WORD, valid=0; bubble_count=3; then normal advance.
- stall held 3 consecutive cycles with MAX_STALL=2: stall_err sets at the 3rd edge and stays 1 after stall drops. Async rst_n pulse mid-cycle clears it and sets pc=PC_RESET without a clock edge.
- pc preloaded via flush to 0xFFFF_FFFC, one advance: pc=0x0, if_id_pc4=0x0. stall_count driven 2^CNT_W+5 times stays 0xFFFF.
